// File: rtl/sdram_cmd_queue.sv
// Host-side command FIFO feeding the SDRAM control FSM's local_* port.
// Commands are issued one at a time using the FSM's level-sampled ready handshake.
module sdram_cmd_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 25,
    parameter int unsigned DW    = 32
) (
    input  logic          clk,
    input  logic          soft_rst,
    input  logic          host_write,
    input  logic          host_read,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_waitrequest,
    output logic [DW-1:0] host_readdata,
    output logic          host_readdatavalid,
    output logic          local_write,
    output logic          local_read,
    output logic [AW-1:0] local_addr,
    output logic [DW-1:0] local_wdata,
    input  logic          local_ready,
    input  logic          local_rddatavalid,
    input  logic [DW-1:0] local_rdata
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned PW = IW + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT
    } state_t;

    state_t        state_q, state_d;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] count;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    logic          mem_is_wr_q [DEPTH];
    logic [AW-1:0] mem_addr_q  [DEPTH];
    logic [DW-1:0] mem_wdata_q [DEPTH];

    logic          local_write_q, local_write_d;
    logic          local_read_q, local_read_d;
    logic [AW-1:0] local_addr_q, local_addr_d;
    logic [DW-1:0] local_wdata_q, local_wdata_d;
    logic          rd_pend_q, rd_pend_d;
    logic [DW-1:0] host_readdata_q, host_readdata_d;
    logic          host_readdatavalid_q, host_readdatavalid_d;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign count = wr_ptr_q - rd_ptr_q;
    assign full  = (count == PW'(DEPTH));
    assign empty = (count == '0);

    // A simultaneous write and read request is stored as a write only.
    assign push  = (host_write | host_read) & ~full;

    assign wr_ptr_d = wr_ptr_q + PW'(push);
    assign rd_ptr_d = rd_ptr_q + PW'(pop);

    always_ff @(posedge clk) begin
        if (push) begin
            mem_is_wr_q[wr_ptr_q[IW-1:0]] <= host_write;
            mem_addr_q[wr_ptr_q[IW-1:0]]  <= host_addr;
            mem_wdata_q[wr_ptr_q[IW-1:0]] <= host_wdata;
        end
    end

    always_comb begin
        state_d              = state_q;
        local_write_d        = local_write_q;
        local_read_d         = local_read_q;
        local_addr_d         = local_addr_q;
        local_wdata_d        = local_wdata_q;
        rd_pend_d            = rd_pend_q;
        host_readdata_d      = host_readdata_q;
        host_readdatavalid_d = 1'b0;
        pop                  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!empty && local_ready) begin
                    local_addr_d  = mem_addr_q[rd_ptr_q[IW-1:0]];
                    local_wdata_d = mem_wdata_q[rd_ptr_q[IW-1:0]];
                    local_write_d = mem_is_wr_q[rd_ptr_q[IW-1:0]];
                    local_read_d  = ~mem_is_wr_q[rd_ptr_q[IW-1:0]];
                    state_d       = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // The entry stays in the FIFO until the FSM signals acceptance by going busy.
                if (!local_ready) begin
                    local_write_d = 1'b0;
                    local_read_d  = 1'b0;
                    pop           = 1'b1;
                    rd_pend_d     = local_read_q;
                    state_d       = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (local_ready) begin
                    state_d   = ST_IDLE;
                    rd_pend_d = 1'b0;
                    if (rd_pend_q && local_rddatavalid) begin
                        host_readdata_d      = local_rdata;
                        host_readdatavalid_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge soft_rst) begin
        if (soft_rst) begin
            state_q              <= ST_IDLE;
            wr_ptr_q             <= '0;
            rd_ptr_q             <= '0;
            local_write_q        <= 1'b0;
            local_read_q         <= 1'b0;
            local_addr_q         <= '0;
            local_wdata_q        <= '0;
            rd_pend_q            <= 1'b0;
            host_readdata_q      <= '0;
            host_readdatavalid_q <= 1'b0;
        end else begin
            state_q              <= state_d;
            wr_ptr_q             <= wr_ptr_d;
            rd_ptr_q             <= rd_ptr_d;
            local_write_q        <= local_write_d;
            local_read_q         <= local_read_d;
            local_addr_q         <= local_addr_d;
            local_wdata_q        <= local_wdata_d;
            rd_pend_q            <= rd_pend_d;
            host_readdata_q      <= host_readdata_d;
            host_readdatavalid_q <= host_readdatavalid_d;
        end
    end

    assign host_waitrequest   = full;
    assign host_readdata      = host_readdata_q;
    assign host_readdatavalid = host_readdatavalid_q;
    assign local_write        = local_write_q;
    assign local_read         = local_read_q;
    assign local_addr         = local_addr_q;
    assign local_wdata        = local_wdata_q;

endmodule

// File: tb/tb_sdram_cmd_queue.sv
// Directed bench for sdram_cmd_queue: the SDRAM FSM side is driven by hand per scenario.
module tb_sdram_cmd_queue;

    localparam int unsigned AW = 25;
    localparam int unsigned DW = 32;

    logic          clk;
    logic          soft_rst;
    logic          host_write;
    logic          host_read;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_waitrequest;
    logic [DW-1:0] host_readdata;
    logic          host_readdatavalid;
    logic          local_write;
    logic          local_read;
    logic [AW-1:0] local_addr;
    logic [DW-1:0] local_wdata;
    logic          local_ready;
    logic          local_rddatavalid;
    logic [DW-1:0] local_rdata;

    int checks;
    int failures;
    int rdv_cnt;

    sdram_cmd_queue #(
        .DEPTH(4),
        .AW   (AW),
        .DW   (DW)
    ) dut (
        .clk               (clk),
        .soft_rst          (soft_rst),
        .host_write        (host_write),
        .host_read         (host_read),
        .host_addr         (host_addr),
        .host_wdata        (host_wdata),
        .host_waitrequest  (host_waitrequest),
        .host_readdata     (host_readdata),
        .host_readdatavalid(host_readdatavalid),
        .local_write       (local_write),
        .local_read        (local_read),
        .local_addr        (local_addr),
        .local_wdata       (local_wdata),
        .local_ready       (local_ready),
        .local_rddatavalid (local_rddatavalid),
        .local_rdata       (local_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (host_readdatavalid === 1'b1) rdv_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Plays the FSM for one command: sample it, accept one cycle later, stay busy, then go ready.
    task automatic serve(input logic rd_resp, input logic [DW-1:0] rdata,
                         output bit tmo, output logic was_rd,
                         output logic [AW-1:0] a, output logic [DW-1:0] d,
                         output bit unstable, output bit not_cleared,
                         output logic rdv_rise, output logic [DW-1:0] rdat_rise,
                         output logic rdv_next);
        tmo = 1'b1; was_rd = 1'b0; a = '0; d = '0; unstable = 1'b0;
        not_cleared = 1'b0; rdv_rise = 1'b0; rdat_rise = '0; rdv_next = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (local_write || local_read) begin
                tmo = 1'b0;
                break;
            end
            cyc();
        end
        if (tmo) return;
        was_rd = local_read;
        a      = local_addr;
        d      = local_wdata;
        cyc();
        unstable = (local_addr !== a) || (local_wdata !== d) ||
                   (local_read !== was_rd) || (local_write !== !was_rd);
        local_ready = 1'b0;
        cyc();
        not_cleared = local_write || local_read;
        repeat (2) cyc();
        local_ready       = 1'b1;
        local_rddatavalid = rd_resp;
        local_rdata       = rdata;
        cyc();
        rdv_rise  = host_readdatavalid;
        rdat_rise = host_readdata;
        local_rddatavalid = 1'b0;
        local_rdata       = '0;
        cyc();
        rdv_next = host_readdatavalid;
    endtask

    task automatic test_reset();
        soft_rst = 1'b1;
        repeat (3) cyc();
        checks++; if (local_write !== 1'b0) begin failures++; $display("FAIL rst_local_write got=%b exp=0", local_write); end
        checks++; if (local_read !== 1'b0) begin failures++; $display("FAIL rst_local_read got=%b exp=0", local_read); end
        checks++; if (local_addr !== '0) begin failures++; $display("FAIL rst_local_addr got=%h exp=0", local_addr); end
        checks++; if (local_wdata !== '0) begin failures++; $display("FAIL rst_local_wdata got=%h exp=0", local_wdata); end
        checks++; if (host_readdata !== '0) begin failures++; $display("FAIL rst_readdata got=%h exp=0", host_readdata); end
        checks++; if (host_readdatavalid !== 1'b0) begin failures++; $display("FAIL rst_rdv got=%b exp=0", host_readdatavalid); end
        checks++; if (host_waitrequest !== 1'b0) begin failures++; $display("FAIL rst_waitreq got=%b exp=0", host_waitrequest); end
        checks++; if (dut.count !== 3'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", dut.count); end
        soft_rst = 1'b0;
        cyc();
    endtask

    task automatic test_init_holdoff();
        bit tmo, uns, ncl;
        logic wrd, rr, rn;
        logic [AW-1:0] a;
        logic [DW-1:0] d, rdat;
        int viol;
        local_ready = 1'b0;
        host_write = 1'b1; host_addr = 25'h0123456; host_wdata = 32'h11111111;
        cyc();
        host_write = 1'b0; host_read = 1'b1; host_addr = 25'h0000200; host_wdata = 32'h0;
        cyc();
        host_read = 1'b0;
        viol = 0;
        repeat (50) begin
            if (local_write || local_read) viol++;
            cyc();
        end
        checks++; if (viol !== 0) begin failures++; $display("FAIL init_no_issue got=%0d exp=0", viol); end
        checks++; if (dut.count !== 3'd2) begin failures++; $display("FAIL init_count got=%0d exp=2", dut.count); end
        local_ready = 1'b1;
        serve(1'b0, '0, tmo, wrd, a, d, uns, ncl, rr, rdat, rn);
        checks++; if (tmo || wrd !== 1'b0 || a !== 25'h0123456 || d !== 32'h11111111) begin
            failures++; $display("FAIL init_first_cmd got=tmo%0d rd%b %h/%h exp=wr 0123456/11111111", tmo, wrd, a, d); end
        serve(1'b1, 32'hCAFEF00D, tmo, wrd, a, d, uns, ncl, rr, rdat, rn);
        checks++; if (tmo || wrd !== 1'b1 || a !== 25'h0000200) begin
            failures++; $display("FAIL init_second_cmd got=tmo%0d rd%b %h exp=rd 0000200", tmo, wrd, a); end
        checks++; if (rr !== 1'b1 || rdat !== 32'hCAFEF00D || rn !== 1'b0) begin
            failures++; $display("FAIL init_read_data got=rdv%b %h next%b exp=1 cafef00d 0", rr, rdat, rn); end
    endtask

    task automatic test_single_write();
        int c0;
        c0 = rdv_cnt;
        local_ready = 1'b1;
        host_write = 1'b1; host_addr = 25'h01A2B3C; host_wdata = 32'hDEADBEEF;
        cyc();
        host_write = 1'b0;
        checks++; if (local_write !== 1'b0) begin failures++; $display("FAIL sw_not_early got=%b exp=0", local_write); end
        cyc();
        checks++; if (local_write !== 1'b1 || local_read !== 1'b0) begin
            failures++; $display("FAIL sw_issue got=w%b r%b exp=w1 r0", local_write, local_read); end
        checks++; if (local_addr !== 25'h01A2B3C || local_wdata !== 32'hDEADBEEF) begin
            failures++; $display("FAIL sw_payload got=%h/%h exp=01a2b3c/deadbeef", local_addr, local_wdata); end
        cyc();
        checks++; if (local_write !== 1'b1 || local_addr !== 25'h01A2B3C) begin
            failures++; $display("FAIL sw_hold got=w%b %h exp=w1 01a2b3c", local_write, local_addr); end
        local_ready = 1'b0;
        cyc();
        checks++; if (local_write !== 1'b0) begin failures++; $display("FAIL sw_clear got=%b exp=0", local_write); end
        repeat (2) cyc();
        local_ready = 1'b1;
        repeat (3) cyc();
        checks++; if (rdv_cnt !== c0) begin failures++; $display("FAIL sw_no_rdv got=%0d exp=%0d", rdv_cnt, c0); end
        checks++; if (dut.count !== 3'd0) begin failures++; $display("FAIL sw_count got=%0d exp=0", dut.count); end
    endtask

    task automatic test_read_after_write();
        bit tmo, uns, ncl;
        logic wrd, rr, rn;
        logic [AW-1:0] a;
        logic [DW-1:0] d, rdat;
        int c0;
        c0 = rdv_cnt;
        local_ready = 1'b1;
        host_write = 1'b1; host_addr = 25'h0000010; host_wdata = 32'h12345678;
        cyc();
        host_write = 1'b0; host_read = 1'b1; host_wdata = 32'h0;
        cyc();
        host_read = 1'b0;
        serve(1'b0, '0, tmo, wrd, a, d, uns, ncl, rr, rdat, rn);
        checks++; if (tmo || wrd !== 1'b0 || a !== 25'h0000010 || d !== 32'h12345678 || uns || ncl) begin
            failures++; $display("FAIL raw_write got=tmo%0d rd%b %h/%h uns%0d ncl%0d exp=wr 0000010/12345678", tmo, wrd, a, d, uns, ncl); end
        checks++; if (rr !== 1'b0) begin failures++; $display("FAIL raw_write_no_rdv got=%b exp=0", rr); end
        serve(1'b1, 32'h12345678, tmo, wrd, a, d, uns, ncl, rr, rdat, rn);
        checks++; if (tmo || wrd !== 1'b1 || a !== 25'h0000010 || uns || ncl) begin
            failures++; $display("FAIL raw_read got=tmo%0d rd%b %h exp=rd 0000010", tmo, wrd, a); end
        checks++; if (rr !== 1'b1 || rdat !== 32'h12345678) begin
            failures++; $display("FAIL raw_rdata got=rdv%b %h exp=1 12345678", rr, rdat); end
        checks++; if (rn !== 1'b0 || rdv_cnt - c0 !== 1) begin
            failures++; $display("FAIL raw_pulse_once got=next%b cnt%0d exp=0 1", rn, rdv_cnt - c0); end
    endtask

    task automatic test_fill_full();
        bit tmo, uns, ncl;
        logic wrd, rr, rn;
        logic [AW-1:0] a;
        logic [DW-1:0] d, rdat;
        int early;
        local_ready = 1'b0;
        early = 0;
        for (int i = 0; i < 4; i++) begin
            host_write = 1'b1; host_addr = AW'(32'h100 + i); host_wdata = DW'(i);
            if (host_waitrequest !== 1'b0) early++;
            cyc();
        end
        checks++; if (early !== 0) begin failures++; $display("FAIL full_early got=%0d exp=0", early); end
        host_addr = 25'h0000104; host_wdata = 32'd4;
        checks++; if (host_waitrequest !== 1'b1) begin failures++; $display("FAIL full_after4 got=%b exp=1", host_waitrequest); end
        repeat (3) cyc();
        checks++; if (host_waitrequest !== 1'b1 || local_write !== 1'b0 || dut.count !== 3'd4) begin
            failures++; $display("FAIL full_hold got=wr%b lw%b cnt%0d exp=1 0 4", host_waitrequest, local_write, dut.count); end
        local_ready = 1'b1;
        cyc();
        checks++; if (local_write !== 1'b1 || local_addr !== 25'h0000100 || host_waitrequest !== 1'b1) begin
            failures++; $display("FAIL full_issue got=lw%b %h wr%b exp=1 0000100 1", local_write, local_addr, host_waitrequest); end
        cyc();
        local_ready = 1'b0;
        cyc();
        checks++; if (host_waitrequest !== 1'b0 || local_write !== 1'b0) begin
            failures++; $display("FAIL full_pop got=wr%b lw%b exp=0 0", host_waitrequest, local_write); end
        cyc();
        checks++; if (host_waitrequest !== 1'b1 || dut.count !== 3'd4) begin
            failures++; $display("FAIL full_fifth got=wr%b cnt%0d exp=1 4", host_waitrequest, dut.count); end
        host_write = 1'b0; host_addr = '0; host_wdata = '0;
        local_ready = 1'b1;
        cyc();
        for (int i = 1; i < 5; i++) begin
            serve(1'b0, '0, tmo, wrd, a, d, uns, ncl, rr, rdat, rn);
            checks++; if (tmo || wrd !== 1'b0 || a !== AW'(32'h100 + i) || d !== DW'(i)) begin
                failures++; $display("FAIL full_order%0d got=tmo%0d %h/%h exp=%h/%h", i, tmo, a, d, AW'(32'h100 + i), DW'(i)); end
        end
    endtask

    task automatic test_refresh_stall();
        int bad;
        local_ready = 1'b1;
        host_write = 1'b1; host_addr = 25'h00ABCDE; host_wdata = 32'h55AA55AA;
        cyc();
        host_write = 1'b0; host_addr = '0; host_wdata = '0;
        cyc();
        checks++; if (local_write !== 1'b1) begin failures++; $display("FAIL rf_issue got=%b exp=1", local_write); end
        bad = 0;
        repeat (10) begin
            cyc();
            if (local_write !== 1'b1 || local_addr !== 25'h00ABCDE || local_wdata !== 32'h55AA55AA) bad++;
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL rf_stable got=%0d exp=0", bad); end
        local_ready = 1'b0;
        cyc();
        checks++; if (local_write !== 1'b0 || dut.count !== 3'd0) begin
            failures++; $display("FAIL rf_complete got=lw%b cnt%0d exp=0 0", local_write, dut.count); end
        local_ready = 1'b1;
        repeat (2) cyc();
    endtask

    task automatic test_reset_mid_read();
        int c0;
        int bad;
        c0 = rdv_cnt;
        local_ready = 1'b1;
        host_read = 1'b1; host_addr = 25'h0000077;
        cyc();
        host_read = 1'b0;
        cyc();
        checks++; if (local_read !== 1'b1) begin failures++; $display("FAIL rm_issue got=%b exp=1", local_read); end
        cyc();
        local_ready = 1'b0;
        cyc();
        host_write = 1'b1; host_addr = 25'h0000099; host_wdata = 32'h99;
        cyc();
        host_write = 1'b0; host_addr = '0; host_wdata = '0;
        checks++; if (dut.count !== 3'd1) begin failures++; $display("FAIL rm_pre_count got=%0d exp=1", dut.count); end
        #2;
        soft_rst = 1'b1;
        #1;
        checks++; if (local_write !== 1'b0 || local_read !== 1'b0 || local_addr !== '0 || local_wdata !== '0) begin
            failures++; $display("FAIL rm_local_zero got=w%b r%b %h/%h exp=0", local_write, local_read, local_addr, local_wdata); end
        checks++; if (host_readdata !== '0 || host_readdatavalid !== 1'b0 || host_waitrequest !== 1'b0) begin
            failures++; $display("FAIL rm_host_zero got=%h v%b w%b exp=0", host_readdata, host_readdatavalid, host_waitrequest); end
        checks++; if (dut.count !== 3'd0) begin failures++; $display("FAIL rm_count got=%0d exp=0", dut.count); end
        local_ready = 1'b1; local_rddatavalid = 1'b1; local_rdata = 32'hBAD0BAD0;
        cyc();
        soft_rst = 1'b0;
        bad = 0;
        repeat (5) begin
            cyc();
            if (local_write || local_read) bad++;
        end
        local_rddatavalid = 1'b0; local_rdata = '0;
        checks++; if (rdv_cnt !== c0) begin failures++; $display("FAIL rm_no_rdv got=%0d exp=%0d", rdv_cnt, c0); end
        checks++; if (bad !== 0) begin failures++; $display("FAIL rm_no_cmd got=%0d exp=0", bad); end
    endtask

    initial begin
        checks = 0; failures = 0; rdv_cnt = 0;
        soft_rst = 1'b1;
        host_write = 1'b0; host_read = 1'b0; host_addr = '0; host_wdata = '0;
        local_ready = 1'b0; local_rddatavalid = 1'b0; local_rdata = '0;
        test_reset();
        test_init_holdoff();
        test_single_write();
        test_read_after_write();
        test_fill_full();
        test_refresh_stall();
        test_reset_mid_read();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
